// File: rtl/calc_pkg.sv
// Shared key codes, operator/state encodings and key classification helpers
// for the calculator keypad front end.
package calc_pkg;

  localparam logic [4:0] KEY_ADD  = 5'd10;
  localparam logic [4:0] KEY_SUB  = 5'd11;
  localparam logic [4:0] KEY_MUL  = 5'd12;
  localparam logic [4:0] KEY_DIV  = 5'd13;
  localparam logic [4:0] KEY_EQ   = 5'd14;
  localparam logic [4:0] KEY_CLR  = 5'd15;
  localparam logic [4:0] KEY_BKSP = 5'd16;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ENTRY,
    LATCH,
    CALC,
    RESULT
  } state_t;

  function automatic logic is_digit(input logic [4:0] code);
    return code <= 5'd9;
  endfunction

  function automatic logic is_op(input logic [4:0] code);
    return (code >= KEY_ADD) && (code <= KEY_DIV);
  endfunction

  function automatic op_t code_to_op(input logic [4:0] code);
    op_t op;
    case (code)
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      KEY_DIV: op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/bcd_entry_buf.sv
// Live BCD entry buffer: shift-in with leading-zero suppression, backspace,
// clear and reload with a single digit.
module bcd_entry_buf #(
  parameter int unsigned DIGITS = 4,
  localparam int unsigned DW = DIGITS * 4,
  localparam int unsigned CW = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic          push,
  input  logic          pop,
  input  logic [3:0]    digit,
  output logic [DW-1:0] digit_buf,
  output logic [CW-1:0] digit_count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] buf_q, buf_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] shifted;

  assign shifted = (buf_q << 4) | DW'(digit);
  assign full    = (count_q == CW'(DIGITS));
  assign empty   = (count_q == '0);

  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    if (clear) begin
      buf_d   = '0;
      count_d = '0;
    end else if (load) begin
      // A reload with 0 is a leading zero and leaves the buffer empty.
      buf_d   = DW'(digit);
      count_d = (digit != 4'd0) ? CW'(1) : '0;
    end else if (push && !full && !(empty && digit == 4'd0)) begin
      buf_d   = shifted;
      count_d = count_q + CW'(1);
    end else if (pop && !empty) begin
      buf_d   = buf_q >> 4;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  assign digit_buf   = buf_q;
  assign digit_count = count_q;

endmodule

// File: rtl/operand_entry_ctrl.sv
// Keypad entry controller: collects N_OPERANDS BCD operands and the operators
// between them, then hands the latched expression to the ALU with calc_start.
module operand_entry_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned N_OPERANDS = 2,
  parameter int unsigned OPW        = 2,
  localparam int unsigned DW = DIGITS * 4,
  localparam int unsigned CW = $clog2(DIGITS + 1),
  localparam int unsigned IW = $clog2(N_OPERANDS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         key_valid,
  input  logic [4:0]                   key_code,
  output logic                         key_ready,
  output logic [DW-1:0]                digit_buf,
  output logic [CW-1:0]                digit_count,
  output logic [IW-1:0]                operand_idx,
  output logic                         disp_en,
  output logic [N_OPERANDS*DW-1:0]     operand_bus,
  output logic [(N_OPERANDS-1)*OPW-1:0] op_bus,
  output logic                         operand_done,
  output logic                         calc_start,
  output logic                         key_err
);

  state_t                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [N_OPERANDS*DW-1:0]       obus_q, obus_d;
  logic [(N_OPERANDS-1)*OPW-1:0]  opbus_q, opbus_d;
  logic                           done_q, done_d;
  logic                           calc_q, calc_d;
  logic                           err_q, err_d;
  logic                           disp_q, disp_d;
  logic                           ready_q, ready_d;

  logic buf_clear, buf_load, buf_push, buf_pop;
  logic buf_full, buf_empty;
  logic accept, last_idx, clear_all;

  bcd_entry_buf #(
    .DIGITS (DIGITS)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .clear       (buf_clear),
    .load        (buf_load),
    .push        (buf_push),
    .pop         (buf_pop),
    .digit       (key_code[3:0]),
    .digit_buf   (digit_buf),
    .digit_count (digit_count),
    .full        (buf_full),
    .empty       (buf_empty)
  );

  assign last_idx = (idx_q == IW'(N_OPERANDS - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    obus_d    = obus_q;
    opbus_d   = opbus_q;
    done_d    = 1'b0;
    calc_d    = 1'b0;
    err_d     = 1'b0;
    disp_d    = 1'b0;
    buf_clear = 1'b0;
    buf_load  = 1'b0;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    clear_all = 1'b0;
    accept    = key_valid && ((state_q == ENTRY) || (state_q == RESULT));

    unique case (state_q)
      ENTRY: begin
        if (accept) begin
          if (is_digit(key_code)) begin
            if (buf_full) begin
              err_d = 1'b1;
            end else begin
              buf_push = 1'b1;
              disp_d   = 1'b1;
            end
          end else if (is_op(key_code)) begin
            if (last_idx) begin
              err_d = 1'b1;
            end else begin
              opbus_d[idx_q*OPW +: OPW] = OPW'(code_to_op(key_code));
              obus_d[idx_q*DW +: DW]    = digit_buf;
              done_d                    = 1'b1;
              state_d                   = LATCH;
            end
          end else if (key_code == KEY_EQ) begin
            if (last_idx) begin
              obus_d[idx_q*DW +: DW] = digit_buf;
              done_d                 = 1'b1;
              state_d                = LATCH;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_code == KEY_CLR) begin
            clear_all = 1'b1;
          end else if (key_code == KEY_BKSP) begin
            if (!buf_empty) begin
              buf_pop = 1'b1;
              disp_d  = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LATCH: begin
        // The last operand can only be latched by EQ, so it leads to CALC.
        if (last_idx) begin
          calc_d  = 1'b1;
          state_d = CALC;
        end else begin
          idx_d     = idx_q + IW'(1);
          buf_clear = 1'b1;
          disp_d    = 1'b1;
          state_d   = ENTRY;
        end
      end
      CALC: begin
        state_d = RESULT;
      end
      RESULT: begin
        if (accept) begin
          if (is_digit(key_code)) begin
            idx_d    = '0;
            obus_d   = '0;
            opbus_d  = '0;
            buf_load = 1'b1;
            disp_d   = 1'b1;
            state_d  = ENTRY;
          end else if (key_code == KEY_CLR) begin
            clear_all = 1'b1;
          end else if (key_code != KEY_BKSP) begin
            err_d = 1'b1;
          end
        end
      end
    endcase

    if (clear_all) begin
      state_d   = ENTRY;
      idx_d     = '0;
      obus_d    = '0;
      opbus_d   = '0;
      buf_clear = 1'b1;
      disp_d    = 1'b1;
    end

    ready_d = (state_d == ENTRY) || (state_d == RESULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTRY;
      idx_q   <= '0;
      obus_q  <= '0;
      opbus_q <= '0;
      done_q  <= 1'b0;
      calc_q  <= 1'b0;
      err_q   <= 1'b0;
      disp_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      obus_q  <= obus_d;
      opbus_q <= opbus_d;
      done_q  <= done_d;
      calc_q  <= calc_d;
      err_q   <= err_d;
      disp_q  <= disp_d;
      ready_q <= ready_d;
    end
  end

  assign key_ready    = ready_q;
  assign operand_idx  = idx_q;
  assign disp_en      = disp_q;
  assign operand_bus  = obus_q;
  assign op_bus       = opbus_q;
  assign operand_done = done_q;
  assign calc_start   = calc_q;
  assign key_err      = err_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Bench for operand_entry_ctrl: a 2-operand instance driven from a vector
// table plus hand sequences, and a 3-operand instance for operator ordering.
module tb_operand_entry_ctrl;

  localparam logic [4:0] K_ADD = 5'd10, K_MUL = 5'd12, K_EQ = 5'd14;
  localparam logic [4:0] K_CLR = 5'd15, K_BKSP = 5'd16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic kv2 = 1'b0, kv3 = 1'b0;
  logic [4:0] key_code = '0;

  logic        kr2, disp2, done2, calc2, err2;
  logic [15:0] buf2;
  logic [2:0]  cnt2;
  logic [0:0]  idx2;
  logic [31:0] obus2;
  logic [1:0]  opb2;

  logic        kr3, disp3, done3, calc3, err3;
  logic [15:0] buf3;
  logic [2:0]  cnt3;
  logic [1:0]  idx3;
  logic [47:0] obus3;
  logic [3:0]  opb3;

  int checks = 0;
  int failures = 0;
  int done2_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (done2) done2_cnt <= done2_cnt + 1;

  operand_entry_ctrl #(.DIGITS(4), .N_OPERANDS(2), .OPW(2)) dut2 (
    .clk(clk), .reset(reset), .key_valid(kv2), .key_code(key_code), .key_ready(kr2),
    .digit_buf(buf2), .digit_count(cnt2), .operand_idx(idx2), .disp_en(disp2),
    .operand_bus(obus2), .op_bus(opb2), .operand_done(done2), .calc_start(calc2),
    .key_err(err2)
  );

  operand_entry_ctrl #(.DIGITS(4), .N_OPERANDS(3), .OPW(2)) dut3 (
    .clk(clk), .reset(reset), .key_valid(kv3), .key_code(key_code), .key_ready(kr3),
    .digit_buf(buf3), .digit_count(cnt3), .operand_idx(idx3), .disp_en(disp3),
    .operand_bus(obus3), .op_bus(opb3), .operand_done(done3), .calc_start(calc3),
    .key_err(err3)
  );

  typedef struct {
    logic [4:0]  key;
    logic [15:0] exp_buf;
    logic [2:0]  exp_cnt;
    logic        exp_disp;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] code, input bit to3);
    @(negedge clk);
    key_code = code;
    if (to3) kv3 = 1'b1;
    else kv2 = 1'b1;
    @(posedge clk);
    #1;
    kv2 = 1'b0;
    kv3 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{5'd9,   16'h0009, 3'd1, 1'b1, 1'b0};
    vecs[1]  = '{5'd8,   16'h0098, 3'd2, 1'b1, 1'b0};
    vecs[2]  = '{5'd7,   16'h0987, 3'd3, 1'b1, 1'b0};
    vecs[3]  = '{5'd6,   16'h9876, 3'd4, 1'b1, 1'b0};
    vecs[4]  = '{5'd5,   16'h9876, 3'd4, 1'b0, 1'b1};
    vecs[5]  = '{K_BKSP, 16'h0987, 3'd3, 1'b1, 1'b0};
    vecs[6]  = '{5'd20,  16'h0987, 3'd3, 1'b0, 1'b1};
    vecs[7]  = '{K_EQ,   16'h0987, 3'd3, 1'b0, 1'b1};
    vecs[8]  = '{K_CLR,  16'h0000, 3'd0, 1'b1, 1'b0};
    vecs[9]  = '{5'd0,   16'h0000, 3'd0, 1'b1, 1'b0};
    vecs[10] = '{5'd0,   16'h0000, 3'd0, 1'b1, 1'b0};
    vecs[11] = '{5'd7,   16'h0007, 3'd1, 1'b1, 1'b0};
    vecs[12] = '{K_BKSP, 16'h0000, 3'd0, 1'b1, 1'b0};
    vecs[13] = '{K_BKSP, 16'h0000, 3'd0, 1'b0, 1'b0};
    vecs[14] = '{5'd3,   16'h0003, 3'd1, 1'b1, 1'b0};

    // Reset state
    do_reset();
    #1;
    chk("rst_ready", kr2, 1'b1);
    chk("rst_buf", {buf2, 1'b0, cnt2, 3'b0, idx2}, '0);
    chk("rst_buses", {obus2, opb2}, '0);
    chk("rst_pulses", {disp2, done2, calc2, err2}, '0);
    chk("rst3_state", {kr3, buf3, idx3, obus3, opb3}, {1'b1, 70'h0});

    // Table vectors through the scoreboard
    foreach (vecs[i]) begin
      vec_t e;
      exp_q.push_back(vecs[i]);
      press(vecs[i].key, 1'b0);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_buf", i), buf2, e.exp_buf);
      chk($sformatf("vec%0d_cnt", i), cnt2, e.exp_cnt);
      chk($sformatf("vec%0d_disp", i), disp2, e.exp_disp);
      chk($sformatf("vec%0d_err", i), err2, e.exp_err);
    end

    // 1,2,ADD,3,EQ with a key held during LATCH and an operator at the last operand
    do_reset();
    begin
      int base;
      base = done2_cnt;
      press(5'd1, 1'b0);
      press(5'd2, 1'b0);
      press(K_ADD, 1'b0);
      chk("add_latch_done", done2, 1'b1);
      chk("add_latch_ready", kr2, 1'b0);
      chk("add_latch_bus", {obus2, opb2}, {32'h0000_0012, 2'b00});
      key_code = 5'd5;
      kv2 = 1'b1;
      tick();
      kv2 = 1'b0;
      chk("latch_drop_err", err2, 1'b0);
      chk("latch_next", {buf2, idx2, disp2, kr2, done2}, {16'h0000, 1'b1, 1'b1, 1'b1, 1'b0});
      press(5'd3, 1'b0);
      chk("op2_buf", buf2, 16'h0003);
      press(K_ADD, 1'b0);
      chk("op_at_last_err", {err2, done2, kr2, idx2}, {1'b1, 1'b0, 1'b1, 1'b1});
      press(K_EQ, 1'b0);
      chk("eq_latch", {done2, kr2, calc2}, {1'b1, 1'b0, 1'b0});
      chk("eq_bus", {obus2, opb2}, {32'h0003_0012, 2'b00});
      tick();
      chk("calc_pulse", {calc2, kr2, done2}, {1'b1, 1'b0, 1'b0});
      tick();
      chk("result_state", {calc2, kr2}, {1'b0, 1'b1});
      chk("done_count", done2_cnt - base, 2);
      press(K_ADD, 1'b0);
      chk("result_op_err", {err2, obus2}, {1'b1, 32'h0003_0012});
    end

    // Three operands: operator ordering and restart from RESULT
    do_reset();
    press(5'd1, 1'b1);
    press(K_ADD, 1'b1);
    tick();
    press(5'd2, 1'b1);
    press(K_MUL, 1'b1);
    tick();
    press(5'd3, 1'b1);
    press(K_EQ, 1'b1);
    tick();
    chk("n3_calc", calc3, 1'b1);
    tick();
    chk("n3_opbus", opb3, 4'b1000);
    chk("n3_obus", obus3, 48'h0003_0002_0001);
    press(5'd4, 1'b1);
    chk("n3_restart", {obus3, opb3, buf3, idx3, disp3}, {48'h0, 4'h0, 16'h0004, 2'd0, 1'b1});

    // Reset while latching the last operand aborts the calculation
    do_reset();
    press(5'd1, 1'b0);
    press(K_ADD, 1'b0);
    tick();
    press(5'd2, 1'b0);
    press(K_EQ, 1'b0);
    reset = 1'b1;
    tick();
    chk("abort_pulses", {calc2, done2, err2, disp2}, 4'b0000);
    chk("abort_state", {kr2, buf2, idx2, obus2, opb2}, {1'b1, 51'h0});
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("abort_no_calc", {calc2, kr2}, {1'b0, 1'b1});

    // CLR mid-entry
    press(5'd5, 1'b0);
    press(K_ADD, 1'b0);
    tick();
    press(5'd6, 1'b0);
    chk("pre_clr", {buf2, idx2}, {16'h0006, 1'b1});
    press(K_CLR, 1'b0);
    chk("clr", {buf2, cnt2, idx2, disp2, obus2, opb2}, {16'h0, 3'd0, 1'b0, 1'b1, 34'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
